// File: rtl/audio_clk_gen_if.sv
// audio_clk_gen_if: valid/ready config write port for audio_clk_gen.
// master drives a write request, slave (the clock generator) returns ready.
interface audio_clk_gen_if #(
    parameter int DIV_W  = 8,
    parameter int FRAC_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_sel;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic [FRAC_W-1:0] cfg_frac;

    modport master (output cfg_valid, cfg_sel, cfg_div, cfg_phase, cfg_frac,
                    input  cfg_ready);
    modport slave  (input  cfg_valid, cfg_sel, cfg_div, cfg_phase, cfg_frac,
                    output cfg_ready);
endinterface

// File: rtl/audio_clk_gen.sv
// audio_clk_gen: NUM_CLOCKS integer-divided clocks from refclk, each with its
// own divide ratio and phase offset, all aligned to one origin at lock.
// Writes through the cfg port restart every channel so they re-align.
// Optional macro AUDIO_CLK_GEN_FRAC_EN adds a per-channel fractional
// accumulator that stretches the low phase by one cycle on carry-out.
module audio_clk_gen #(
    parameter int NUM_CLOCKS    = 3,
    parameter int DIV_W         = 8,
    parameter int DEFAULT_DIV   = 5,
    parameter int DEFAULT_PHASE = 0,
    parameter int LOCK_DELAY    = 16,
    parameter int FRAC_W        = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    audio_clk_gen_if.slave        cfg,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic                  locked
);
    localparam int CNT_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

    typedef enum logic [1:0] {SETTLE, RUN, RESTART} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] settle_cnt, settle_cnt_next;
    logic             ready;
    logic             xfer;
    logic             sel_hit;
    logic             run_en;
    logic [DIV_W-1:0] div_clamp;
    logic [DIV_W-1:0] phase_clamp;

    assign cfg.cfg_ready = ready;
    // ready is only high in RUN, so a transfer can only happen in RUN
    assign xfer    = cfg.cfg_valid && ready;
    assign sel_hit = int'(cfg.cfg_sel) < NUM_CLOCKS;

    // Clamp at write time so the stored values are always legal
    assign div_clamp   = (cfg.cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg.cfg_div;
    assign phase_clamp = (cfg.cfg_phase >= div_clamp) ? div_clamp - DIV_W'(1)
                                                      : cfg.cfg_phase;

    // Channels only advance while staying in RUN; the edge that leaves RUN
    // (restart) and the edge that enters it both reload the counters
    assign run_en = (state == RUN) && (state_next == RUN);

    // Next-state logic: settle countdown, relock on an in-range write
    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        case (state)
            SETTLE: begin
                if (settle_cnt == CNT_W'(LOCK_DELAY - 1)) begin
                    state_next      = RUN;
                    settle_cnt_next = '0;
                end else begin
                    settle_cnt_next = settle_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (xfer && sel_hit) state_next = RESTART;
            end
            RESTART: begin
                state_next      = SETTLE;
                settle_cnt_next = '0;
            end
            default: begin
                state_next      = SETTLE;
                settle_cnt_next = '0;
            end
        endcase
    end

    // State register plus registered locked/ready, both high exactly in RUN
    always_ff @(posedge refclk) begin
        if (rst) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            locked     <= 1'b0;
            ready      <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
            locked     <= (state_next == RUN);
            ready      <= (state_next == RUN);
        end
    end

    for (genvar k = 0; k < NUM_CLOCKS; k++) begin : g_ch
        logic [DIV_W-1:0] div_q, phase_q;
        logic [DIV_W-1:0] phase_cnt, per_cnt;
        logic [DIV_W:0]   last;
        logic             clk_q;
        logic             wr;

        assign wr        = xfer && (int'(cfg.cfg_sel) == k);
        assign outclk[k] = clk_q;

        // Shadow divide/phase; reset wins over a simultaneous write
        always_ff @(posedge refclk) begin
            if (rst) begin
                div_q   <= DIV_W'(DEFAULT_DIV);
                phase_q <= DIV_W'(DEFAULT_PHASE);
            end else if (wr) begin
                div_q   <= div_clamp;
                phase_q <= phase_clamp;
            end
        end

`ifdef AUDIO_CLK_GEN_FRAC_EN
        logic [FRAC_W-1:0] frac_q, acc;
        logic [FRAC_W:0]   acc_sum;
        logic              ext;

        assign acc_sum = {1'b0, acc} + {1'b0, frac_q};
        // The extra cycle lands at the end of the period, i.e. in the low phase
        assign last    = {1'b0, div_q} + {{DIV_W{1'b0}}, ext} - (DIV_W+1)'(1);

        // Shadow fractional part
        always_ff @(posedge refclk) begin
            if (rst)     frac_q <= '0;
            else if (wr) frac_q <= cfg.cfg_frac;
        end
`else
        assign last = {1'b0, div_q} - (DIV_W+1)'(1);
`endif

        // Phase delay, then high floor(D/2) / low for the rest of the period
        always_ff @(posedge refclk) begin
            if (rst || !run_en) begin
                clk_q     <= 1'b0;
                phase_cnt <= phase_q;
                per_cnt   <= '0;
`ifdef AUDIO_CLK_GEN_FRAC_EN
                acc       <= '0;
                ext       <= 1'b0;
`endif
            end else if (phase_cnt != '0) begin
                phase_cnt <= phase_cnt - DIV_W'(1);
            end else begin
                clk_q <= (per_cnt < (div_q >> 1));
                if ({1'b0, per_cnt} == last) begin
                    per_cnt <= '0;
`ifdef AUDIO_CLK_GEN_FRAC_EN
                    acc     <= acc_sum[FRAC_W-1:0];
                    ext     <= acc_sum[FRAC_W];
`endif
                end else begin
                    per_cnt <= per_cnt + DIV_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_clk_gen.sv
// tb_audio_clk_gen: directed stimulus with a scoreboard; the stimulus pushes
// the expected {locked, ready, outclk} for each edge it cares about and a
// separate monitor pops and compares on the falling edge.
module tb_audio_clk_gen;
    localparam int NC = 3;

    localparam int T_RESET   = 0;
    localparam int T_LOCK    = 1;
    localparam int T_DEFAULT = 2;
    localparam int T_WRITE   = 3;
    localparam int T_CH1     = 4;
    localparam int T_DISCARD = 5;
    localparam int T_CLAMP   = 6;
    localparam int T_RSTMID  = 7;
    localparam int T_RSTWR   = 8;
    localparam int T_FRAC    = 9;

    logic          refclk = 1'b0;
    logic          rst;
    logic [NC-1:0] outclk;
    logic          locked;

    audio_clk_gen_if #(.DIV_W(8), .FRAC_W(8)) cfg ();

    audio_clk_gen #(
        .NUM_CLOCKS(NC), .DIV_W(8), .DEFAULT_DIV(5), .DEFAULT_PHASE(0),
        .LOCK_DELAY(16), .FRAC_W(8)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg(cfg), .outclk(outclk), .locked(locked)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        int         tag;
        logic [4:0] val;   // {locked, cfg_ready, outclk}
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_run  = 0;      // edges since locked rose
    int   div_m[NC];
    int   ph_m[NC];

    function automatic string tag_name(input int t);
        case (t)
            T_RESET:   return "reset";
            T_LOCK:    return "lock_delay";
            T_DEFAULT: return "default_run";
            T_WRITE:   return "write_restart";
            T_CH1:     return "ch1_div4_ph1";
            T_DISCARD: return "sel_out_of_range";
            T_CLAMP:   return "clamp_div1_ph7";
            T_RSTMID:  return "reset_mid_settle";
            T_RSTWR:   return "reset_with_write";
            default:   return "frac";
        endcase
    endfunction

    // Expected level n edges after lock: low P+1 edges, then high D/2, low rest
    function automatic logic exp_bit(input int d, input int p, input int n);
        if (n < p + 1) return 1'b0;
        return (((n - p - 1) % d) < (d / 2));
    endfunction

    // Advance one edge and expect the given state after it
    task automatic tick(input logic lk, input logic [NC-1:0] oc, input int tag);
        exp_t e;
        @(posedge refclk);
        #1;
        e.tag = tag;
        e.val = {lk, lk, oc};
        exp_q.push_back(e);
    endtask

    task automatic settle(input int tag);
        repeat (15) tick(1'b0, '0, tag);
        tick(1'b1, '0, tag);
        n_run = 0;
    endtask

    task automatic run(input int cyc, input int tag);
        logic [NC-1:0] oc;
        for (int c = 0; c < cyc; c++) begin
            n_run++;
            for (int k = 0; k < NC; k++) oc[k] = exp_bit(div_m[k], ph_m[k], n_run);
            tick(1'b1, oc, tag);
        end
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [7:0] d,
                             input logic [7:0] p, input logic [7:0] f);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_sel   = sel;
        cfg.cfg_div   = d;
        cfg.cfg_phase = p;
        cfg.cfg_frac  = f;
    endtask

    task automatic defaults();
        for (int k = 0; k < NC; k++) begin
            div_m[k] = 5;
            ph_m[k]  = 0;
        end
    endtask

    // Monitor: compare each expected entry against the DUT mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({locked, cfg.cfg_ready, outclk} !== e.val) begin
                    errors++;
                    $display("FAIL %s t=%0t {locked,ready,outclk} got %b want %b",
                             tag_name(e.tag), $time, {locked, cfg.cfg_ready, outclk}, e.val);
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_sel   = '0;
        cfg.cfg_div   = '0;
        cfg.cfg_phase = '0;
        cfg.cfg_frac  = '0;
        defaults();

        // Reset and default lock: 16 edges, all channels 2 high / 3 low
        repeat (3) tick(1'b0, '0, T_RESET);
        rst = 1'b0;
        settle(T_LOCK);
        run(20, T_DEFAULT);

        // ch1 div=4 phase=1: 1-cycle handshake, 17 cycles unlocked
        cfg_write(3'd1, 8'd4, 8'd1, 8'd0);
        tick(1'b0, '0, T_WRITE);
        cfg.cfg_valid = 1'b0;
        div_m[1] = 4;
        ph_m[1]  = 1;
        tick(1'b0, '0, T_WRITE);
        settle(T_LOCK);
        run(20, T_CH1);

        // Out-of-range select: accepted, discarded, no relock or phase jump
        cfg_write(3'd5, 8'd9, 8'd0, 8'd0);
        run(1, T_DISCARD);
        cfg.cfg_valid = 1'b0;
        run(15, T_DISCARD);

        // Clamp ch2 div=1 phase=7 -> div 2 phase 1; a write held during
        // restart/settle must be ignored since ready is low there
        cfg_write(3'd2, 8'd1, 8'd7, 8'd0);
        tick(1'b0, '0, T_WRITE);
        div_m[2] = 2;
        ph_m[2]  = 1;
        cfg_write(3'd0, 8'd9, 8'd3, 8'd0);
        tick(1'b0, '0, T_WRITE);
        repeat (5) tick(1'b0, '0, T_LOCK);
        cfg.cfg_valid = 1'b0;
        repeat (10) tick(1'b0, '0, T_LOCK);
        tick(1'b1, '0, T_LOCK);
        n_run = 0;
        run(16, T_CLAMP);

        // Reset 8 cycles into settle after a relock: defaults, full 16 again
        cfg_write(3'd0, 8'd3, 8'd2, 8'd0);
        tick(1'b0, '0, T_WRITE);
        cfg.cfg_valid = 1'b0;
        tick(1'b0, '0, T_WRITE);
        repeat (8) tick(1'b0, '0, T_RSTMID);
        rst = 1'b1;
        tick(1'b0, '0, T_RSTMID);
        rst = 1'b0;
        defaults();
        settle(T_LOCK);
        run(15, T_DEFAULT);

        // Reset and a transfer on the same edge mid-RUN: reset wins
        cfg_write(3'd0, 8'd7, 8'd0, 8'd0);
        rst = 1'b1;
        tick(1'b0, '0, T_RSTWR);
        rst = 1'b0;
        cfg.cfg_valid = 1'b0;
        settle(T_LOCK);
        run(15, T_DEFAULT);

        // ch0 div=4 frac=0x80
        cfg_write(3'd0, 8'd4, 8'd0, 8'h80);
        tick(1'b0, '0, T_WRITE);
        cfg.cfg_valid = 1'b0;
        tick(1'b0, '0, T_WRITE);
        settle(T_LOCK);
`ifdef AUDIO_CLK_GEN_FRAC_EN
        begin
            int   rise_t[$];
            int   cyc;
            logic prev;
            prev = 1'b0;
            cyc  = 0;
            while (rise_t.size() < 258 && cyc < 3000) begin
                @(negedge refclk);
                cyc++;
                if (!prev && outclk[0]) rise_t.push_back(cyc);
                prev = outclk[0];
            end
            checks++;
            if (rise_t.size() < 258) begin
                errors++;
                $display("FAIL frac_timeout rises got %0d want 258", rise_t.size());
            end else begin
                // First period ends with acc=0x80 (no carry), second carries
                checks++;
                if (rise_t[2] - rise_t[1] != 4) begin
                    errors++;
                    $display("FAIL frac_period2 got %0d want 4", rise_t[2] - rise_t[1]);
                end
                checks++;
                if (rise_t[3] - rise_t[2] != 5) begin
                    errors++;
                    $display("FAIL frac_period3 got %0d want 5", rise_t[3] - rise_t[2]);
                end
                checks++;
                if (rise_t[257] - rise_t[1] != 1152) begin
                    errors++;
                    $display("FAIL frac_256_periods got %0d want 1152", rise_t[257] - rise_t[1]);
                end
            end
        end
`else
        // Fractional part is ignored: exact period of 4
        div_m[0] = 4;
        run(20, T_FRAC);
`endif

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge refclk);
        @(negedge refclk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
